// File: rtl/ram_2rw_req_sched.sv
`default_nettype none
// ============================================================================
// Module  : ram_2rw_req_sched
// Brief   : Two-port request scheduler in front of a 2rw synchronous RAM.
//           Resolves same-address hazards with alternating priority and
//           buffers read data in a 2-entry FIFO per port so requesters may
//           stall their responses.
// Revision: 1.0 - initial release
// ============================================================================
module ram_2rw_req_sched #(
    parameter int width_p       = -1,
    parameter int els_p         = -1,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     p0_req_v_i,
    input  logic                     p0_req_w_i,
    input  logic [addr_width_lp-1:0] p0_req_addr_i,
    input  logic [width_p-1:0]       p0_req_data_i,
    output logic                     p0_req_ready_o,
    output logic                     p0_resp_v_o,
    output logic [width_p-1:0]       p0_resp_data_o,
    input  logic                     p0_resp_yumi_i,

    input  logic                     p1_req_v_i,
    input  logic                     p1_req_w_i,
    input  logic [addr_width_lp-1:0] p1_req_addr_i,
    input  logic [width_p-1:0]       p1_req_data_i,
    output logic                     p1_req_ready_o,
    output logic                     p1_resp_v_o,
    output logic [width_p-1:0]       p1_resp_data_o,
    input  logic                     p1_resp_yumi_i,

    output logic                     ram_v0_o,
    output logic                     ram_w0_o,
    output logic [addr_width_lp-1:0] ram_addr0_o,
    output logic [width_p-1:0]       ram_data0_o,
    input  logic [width_p-1:0]       ram_data0_i,

    output logic                     ram_v1_o,
    output logic                     ram_w1_o,
    output logic [addr_width_lp-1:0] ram_addr1_o,
    output logic [width_p-1:0]       ram_data1_o,
    input  logic [width_p-1:0]       ram_data1_i
);

    localparam int c_PORTS = 2;

    logic                     w_req_v     [c_PORTS];
    logic                     w_req_w     [c_PORTS];
    logic [addr_width_lp-1:0] w_req_addr  [c_PORTS];
    logic                     w_yumi      [c_PORTS];
    logic [width_p-1:0]       w_ram_rdata [c_PORTS];
    logic                     w_blocked   [c_PORTS];
    logic                     w_ready     [c_PORTS];
    logic                     w_ram_v     [c_PORTS];
    logic                     w_resp_v    [c_PORTS];
    logic [width_p-1:0]       w_resp_data [c_PORTS];
    logic                     w_hazard;
    logic                     r_prio;

    assign w_req_v[0]     = p0_req_v_i;
    assign w_req_v[1]     = p1_req_v_i;
    assign w_req_w[0]     = p0_req_w_i;
    assign w_req_w[1]     = p1_req_w_i;
    assign w_req_addr[0]  = p0_req_addr_i;
    assign w_req_addr[1]  = p1_req_addr_i;
    assign w_yumi[0]      = p0_resp_yumi_i;
    assign w_yumi[1]      = p1_resp_yumi_i;
    assign w_ram_rdata[0] = ram_data0_i;
    assign w_ram_rdata[1] = ram_data1_i;

    // A same-address pair with at least one write is the only conflict the
    // RAM cannot take; read/read to one address is left alone.
    assign w_hazard = p0_req_v_i && p1_req_v_i
                   && (p0_req_addr_i == p1_req_addr_i)
                   && (p0_req_w_i || p1_req_w_i);

    // The port named by r_prio wins a hazard; the other waits a cycle.
    assign w_blocked[0] = w_hazard && r_prio;
    assign w_blocked[1] = w_hazard && !r_prio;

    // Alternate priority after every contested cycle so neither port starves
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_prio <= 1'b0;
        end else if (w_hazard) begin
            r_prio <= !r_prio;
        end
    end

    for (genvar gi = 0; gi < c_PORTS; gi++) begin : g_port
        logic [width_p-1:0] r_fifo [2];
        logic               r_head;
        logic               r_tail;
        logic [1:0]         r_cnt;
        logic               r_inflight;
        logic [2:0]         w_occ;
        logic               w_accept;
        logic               w_pop;

        // Slots committed once this cycle's pop (if any) is taken: the
        // buffered entries plus the read whose data returns this cycle.
        assign w_occ = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_yumi[gi]};

        // Writes never need a response slot, so only reads wait on space.
        assign w_ready[gi] = !reset_i && !w_blocked[gi]
                          && (w_req_w[gi] || (w_occ < 3'd2));
        assign w_accept    = w_req_v[gi] && w_ready[gi];
        assign w_pop       = w_yumi[gi] && (r_cnt != 2'd0);

        assign w_ram_v[gi]     = w_accept;
        assign w_resp_v[gi]    = (r_cnt != 2'd0);
        assign w_resp_data[gi] = r_fifo[r_head];

        // Track the outstanding RAM read and enqueue its data as it returns
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_head     <= 1'b0;
                r_tail     <= 1'b0;
                r_cnt      <= 2'd0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_accept && !w_req_w[gi];
                if (r_inflight) begin
                    r_fifo[r_tail] <= w_ram_rdata[gi];
                    r_tail         <= !r_tail;
                end
                if (w_pop) begin
                    r_head <= !r_head;
                end
                r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
            end
        end

`ifndef SYNTHESIS
        // Catch protocol misuse and capacity violations in simulation
        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                assert (!(w_yumi[gi] && (r_cnt == 2'd0)));
                assert (!(r_inflight && (r_cnt == 2'd2) && !w_pop));
                assert (!(w_accept && (int'(w_req_addr[gi]) >= els_p)));
            end
        end
`endif
    end

    assign p0_req_ready_o = w_ready[0];
    assign p1_req_ready_o = w_ready[1];
    assign p0_resp_v_o    = w_resp_v[0];
    assign p1_resp_v_o    = w_resp_v[1];
    assign p0_resp_data_o = w_resp_data[0];
    assign p1_resp_data_o = w_resp_data[1];

    // RAM port N carries port N's request straight through.
    assign ram_v0_o    = w_ram_v[0];
    assign ram_w0_o    = p0_req_w_i;
    assign ram_addr0_o = p0_req_addr_i;
    assign ram_data0_o = p0_req_data_i;
    assign ram_v1_o    = w_ram_v[1];
    assign ram_w1_o    = p1_req_w_i;
    assign ram_addr1_o = p1_req_addr_i;
    assign ram_data1_o = p1_req_data_i;

endmodule
`default_nettype wire

// File: tb/tb_ram_2rw_req_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_2rw_req_sched
// Brief   : Self-checking bench for ram_2rw_req_sched with a behavioural
//           RAM and a queue-based reference model of accepts and responses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_2rw_req_sched;

    localparam int c_W   = 8;
    localparam int c_ELS = 16;
    localparam int c_AW  = 4;

    typedef struct {
        logic [c_W-1:0] d;
        int             vis;
    } ent_t;

    logic           clk_i   = 1'b0;
    logic           reset_i = 1'b1;
    logic           req_v    [2];
    logic           req_w    [2];
    logic [c_AW-1:0] req_addr[2];
    logic [c_W-1:0] req_data [2];
    logic           yumi     [2];
    logic           rdy      [2];
    logic           rv       [2];
    logic [c_W-1:0] rd       [2];
    logic           ram_v    [2];
    logic           ram_w    [2];
    logic [c_AW-1:0] ram_a   [2];
    logic [c_W-1:0] ram_wd   [2];
    logic [c_W-1:0] ram_rd   [2];
    logic [c_W-1:0] ram      [c_ELS];
    logic           ram_init = 1'b0;

    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc   = 0;
    logic [c_W-1:0] ref_mem [c_ELS];
    ent_t           q0[$];
    ent_t           q1[$];
    logic           mprio = 1'b0;
    logic           want    [2];
    logic           exp_rdy [2];
    logic           exp_acc [2];
    logic           exp_rv  [2];
    logic [c_W-1:0] exp_rd  [2];
    logic           haz;
    int             acc_cnt [2];

    always #5 clk_i = ~clk_i;

    ram_2rw_req_sched #(.width_p(c_W), .els_p(c_ELS)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .p0_req_v_i(req_v[0]), .p0_req_w_i(req_w[0]), .p0_req_addr_i(req_addr[0]),
        .p0_req_data_i(req_data[0]), .p0_req_ready_o(rdy[0]), .p0_resp_v_o(rv[0]),
        .p0_resp_data_o(rd[0]), .p0_resp_yumi_i(yumi[0]),
        .p1_req_v_i(req_v[1]), .p1_req_w_i(req_w[1]), .p1_req_addr_i(req_addr[1]),
        .p1_req_data_i(req_data[1]), .p1_req_ready_o(rdy[1]), .p1_resp_v_o(rv[1]),
        .p1_resp_data_o(rd[1]), .p1_resp_yumi_i(yumi[1]),
        .ram_v0_o(ram_v[0]), .ram_w0_o(ram_w[0]), .ram_addr0_o(ram_a[0]),
        .ram_data0_o(ram_wd[0]), .ram_data0_i(ram_rd[0]),
        .ram_v1_o(ram_v[1]), .ram_w1_o(ram_w[1]), .ram_addr1_o(ram_a[1]),
        .ram_data1_o(ram_wd[1]), .ram_data1_i(ram_rd[1])
    );

    // Behavioural 2rw synchronous RAM
    always @(posedge clk_i) begin
        if (!ram_init) begin
            for (int a = 0; a < c_ELS; a++) ram[a] <= 8'(a * 37 + 5);
            ram_init <= 1'b1;
        end else begin
            for (int p = 0; p < 2; p++)
                if (ram_v[p] && !ram_w[p]) ram_rd[p] <= ram[ram_a[p]];
            for (int p = 0; p < 2; p++)
                if (ram_v[p] && ram_w[p]) ram[ram_a[p]] <= ram_wd[p];
        end
    end

    task automatic set_req(int p, logic v, logic w, int a, int d);
        req_v[p] = v; req_w[p] = w; req_addr[p] = c_AW'(a); req_data[p] = c_W'(d);
    endtask

    task automatic idle();
        set_req(0, 1'b0, 1'b0, 0, 0);
        set_req(1, 1'b0, 1'b0, 0, 0);
    endtask

    // Compute the model's expectations for the current cycle and drive yumi
    task automatic prep();
        int occ;
        haz = req_v[0] && req_v[1] && (req_addr[0] == req_addr[1]) && (req_w[0] || req_w[1]);
        for (int p = 0; p < 2; p++) begin
            exp_rv[p] = 1'b0;
            exp_rd[p] = '0;
        end
        if (q0.size() > 0 && q0[0].vis <= cyc) begin exp_rv[0] = 1'b1; exp_rd[0] = q0[0].d; end
        if (q1.size() > 0 && q1[0].vis <= cyc) begin exp_rv[1] = 1'b1; exp_rd[1] = q1[0].d; end
        for (int p = 0; p < 2; p++) yumi[p] = want[p] && exp_rv[p] && rv[p];
        #1;
        for (int p = 0; p < 2; p++) begin
            occ = (p == 0) ? q0.size() : q1.size();
            exp_rdy[p] = !reset_i && !(haz && (int'(mprio) != p))
                      && (req_w[p] || ((occ - (yumi[p] ? 1 : 0)) < 2));
            exp_acc[p] = req_v[p] && exp_rdy[p];
        end
    endtask

    // Advance one clock and update the model
    task automatic tick();
        ent_t e;
        @(posedge clk_i);
        if (reset_i) begin
            q0.delete(); q1.delete(); mprio = 1'b0;
        end else begin
            if (yumi[0] && exp_rv[0]) void'(q0.pop_front());
            if (yumi[1] && exp_rv[1]) void'(q1.pop_front());
            for (int p = 0; p < 2; p++) begin
                if (exp_acc[p] && !req_w[p]) begin
                    e.d = ref_mem[req_addr[p]]; e.vis = cyc + 2;
                    if (p == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
            for (int p = 0; p < 2; p++)
                if (exp_acc[p] && req_w[p]) ref_mem[req_addr[p]] = req_data[p];
            if (haz) mprio = !mprio;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 1'(i), i, 8'h10 + i);
            set_req(1, 1'b1, 1'b0, i + 4, 0);
            prep();
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (rdy[p] !== 1'b0 || ram_v[p] !== 1'b0 || rv[p] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_outputs p%0d: got ready=%b ram_v=%b resp_v=%b required 0/0/0",
                             p, rdy[p], ram_v[p], rv[p]);
                end
            end
            tick();
        end
        reset_i = 1'b0;
        idle();
        prep();
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if (rv[p] !== 1'b0) begin
                n_err++; $display("FAIL post_reset_resp_v p%0d: got %b required 0", p, rv[p]);
            end
        end
        tick();
    endtask

    task automatic test_write_then_read();
        want[0] = 1'b1; want[1] = 1'b0;
        set_req(0, 1'b1, 1'b1, 5, 8'hA5);
        prep();
        n_cmp++;
        if (rdy[0] !== 1'b1 || ram_v[0] !== 1'b1 || ram_w[0] !== 1'b1 || ram_a[0] !== 4'd5
            || ram_wd[0] !== 8'hA5) begin
            n_err++;
            $display("FAIL raw_write_issue: got ready=%b v=%b w=%b addr=%0d data=%h required 1/1/1/5/a5",
                     rdy[0], ram_v[0], ram_w[0], ram_a[0], ram_wd[0]);
        end
        tick();
        idle();
        set_req(1, 1'b1, 1'b0, 5, 0);
        prep();
        n_cmp++;
        if (rdy[1] !== 1'b1) begin
            n_err++; $display("FAIL raw_read_ready: got %b required 1", rdy[1]);
        end
        tick();
        idle();
        prep();
        n_cmp++;
        if (rv[1] !== 1'b0) begin
            n_err++; $display("FAIL raw_early_resp: got resp_v=%b required 0", rv[1]);
        end
        tick();
        want[1] = 1'b1;
        prep();
        n_cmp++;
        if (rv[1] !== 1'b1 || rd[1] !== 8'hA5) begin
            n_err++; $display("FAIL raw_resp: got v=%b data=%h required 1/a5", rv[1], rd[1]);
        end
        tick();
    endtask

    task automatic test_ww_hazard();
        set_req(0, 1'b1, 1'b1, 3, 8'h01);
        set_req(1, 1'b1, 1'b1, 3, 8'h02);
        prep();
        n_cmp++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0 || ram_v[1] !== 1'b0) begin
            n_err++; $display("FAIL ww_arb: got ready0=%b ready1=%b ram_v1=%b required 1/0/0",
                              rdy[0], rdy[1], ram_v[1]);
        end
        tick();
        set_req(0, 1'b0, 1'b0, 0, 0);
        prep();
        n_cmp++;
        if (rdy[1] !== 1'b1) begin
            n_err++; $display("FAIL ww_loser_retry: got ready1=%b required 1", rdy[1]);
        end
        tick();
        // Priority now belongs to port 1: a fresh hazard must favour it.
        set_req(0, 1'b1, 1'b1, 9, 8'h33);
        set_req(1, 1'b1, 1'b1, 9, 8'h44);
        prep();
        n_cmp++;
        if (rdy[0] !== 1'b0 || rdy[1] !== 1'b1) begin
            n_err++; $display("FAIL prio_flip: got ready0=%b ready1=%b required 0/1", rdy[0], rdy[1]);
        end
        tick();
        set_req(0, 1'b1, 1'b0, 3, 0);
        set_req(1, 1'b0, 1'b0, 0, 0);
        prep();
        tick();
        idle();
        prep();
        tick();
        prep();
        n_cmp++;
        if (rv[0] !== 1'b1 || rd[0] !== 8'h02) begin
            n_err++; $display("FAIL ww_final_value: got v=%b data=%h required 1/02", rv[0], rd[0]);
        end
        tick();
    endtask

    task automatic test_rw_hazard();
        want[0] = 1'b1;
        idle();
        set_req(1, 1'b1, 1'b1, 7, 8'h22);
        prep(); tick();
        set_req(0, 1'b1, 1'b0, 7, 0);
        set_req(1, 1'b1, 1'b1, 7, 8'h11);
        prep();
        n_cmp++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
            n_err++; $display("FAIL rw_arb: got ready0=%b ready1=%b required 1/0", rdy[0], rdy[1]);
        end
        tick();
        set_req(0, 1'b0, 1'b0, 0, 0);
        prep(); tick();
        set_req(0, 1'b1, 1'b0, 7, 0);
        set_req(1, 1'b0, 1'b0, 0, 0);
        prep();
        n_cmp++;
        if (rv[0] !== 1'b1 || rd[0] !== 8'h22) begin
            n_err++; $display("FAIL rw_old_data: got v=%b data=%h required 1/22", rv[0], rd[0]);
        end
        tick();
        idle();
        prep(); tick();
        prep();
        n_cmp++;
        if (rv[0] !== 1'b1 || rd[0] !== 8'h11) begin
            n_err++; $display("FAIL rw_new_data: got v=%b data=%h required 1/11", rv[0], rd[0]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [c_W-1:0] snap [4];
        int idx = 0, got = 0, dut_acc = 0;
        want[0] = 1'b1; want[1] = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) begin prep(); tick(); end
        for (int k = 0; k < 4; k++) snap[k] = ref_mem[k];
        want[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(1, 1'b1, 1'b0, idx, 0);
            prep();
            n_cmp++;
            if (rdy[1] !== exp_rdy[1]) begin
                n_err++; $display("FAIL bp_ready cyc%0d: got %b required %b", i, rdy[1], exp_rdy[1]);
            end
            if (rdy[1] === 1'b1) dut_acc++;
            if (exp_acc[1]) idx++;
            tick();
        end
        n_cmp++;
        if (dut_acc != 2 || rdy[1] !== 1'b0) begin
            n_err++; $display("FAIL bp_stall: got accepts=%0d ready=%b required 2/0", dut_acc, rdy[1]);
        end
        want[1] = 1'b1;
        for (int i = 0; i < 20 && got < 4; i++) begin
            set_req(1, 1'(idx < 4), 1'b0, idx % 4, 0);
            prep();
            n_cmp++;
            if (req_v[1] && rdy[1] !== exp_rdy[1]) begin
                n_err++; $display("FAIL bp_drain_ready: got %b required %b", rdy[1], exp_rdy[1]);
            end
            if (req_v[1] && rdy[1] === 1'b1) dut_acc++;
            if (yumi[1]) begin
                n_cmp++;
                if (rd[1] !== snap[got]) begin
                    n_err++; $display("FAIL bp_order resp%0d: got %h required %h", got, rd[1], snap[got]);
                end
                got++;
            end
            if (exp_acc[1]) idx++;
            tick();
        end
        idle();
        prep();
        n_cmp++;
        if (got != 4 || dut_acc != 4 || rv[1] !== 1'b0) begin
            n_err++; $display("FAIL bp_count: got resps=%0d accepts=%0d extra_v=%b required 4/4/0",
                              got, dut_acc, rv[1]);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        want[0] = 1'b1;
        set_req(0, 1'b1, 1'b0, 2, 0);
        prep();
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
            n_err++; $display("FAIL rst_inflight_accept: got %b required 1", rdy[0]);
        end
        tick();
        idle();
        reset_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) reset_i = 1'b0;
            prep();
            n_cmp++;
            if (rv[0] !== 1'b0) begin
                n_err++; $display("FAIL rst_inflight_resp cyc%0d: got %b required 0", i, rv[0]);
            end
            tick();
        end
        set_req(0, 1'b1, 1'b0, 4, 0);
        prep(); tick();
        idle();
        prep(); tick();
        prep();
        n_cmp++;
        if (rv[0] !== 1'b1 || rd[0] !== ref_mem[4]) begin
            n_err++; $display("FAIL rst_new_read: got v=%b data=%h required 1/%h", rv[0], rd[0], ref_mem[4]);
        end
        tick();
    endtask

    task automatic test_stream();
        int acc [2];
        int rsp [2];
        int a0;
        acc[0] = 0; acc[1] = 0; rsp[0] = 0; rsp[1] = 0;
        want[0] = 1'b1; want[1] = 1'b1;
        for (int i = 0; i < 104; i++) begin
            a0 = $urandom_range(0, c_ELS - 1);
            set_req(0, 1'(i < 100), 1'b0, a0, 0);
            set_req(1, 1'(i < 100), 1'b0, (a0 + $urandom_range(1, c_ELS - 1)) % c_ELS, 0);
            prep();
            for (int p = 0; p < 2; p++) begin
                if (req_v[p]) begin
                    n_cmp++;
                    if (rdy[p] !== 1'b1) begin
                        n_err++; $display("FAIL stream_stall p%0d cyc%0d: got ready=%b required 1", p, i, rdy[p]);
                    end
                    if (rdy[p] === 1'b1) acc[p]++;
                end
                n_cmp++;
                if (rv[p] !== exp_rv[p] || (exp_rv[p] && rd[p] !== exp_rd[p])) begin
                    n_err++; $display("FAIL stream_resp p%0d cyc%0d: got v=%b d=%h required %b/%h",
                                      p, i, rv[p], rd[p], exp_rv[p], exp_rd[p]);
                end
                if (yumi[p]) rsp[p]++;
            end
            tick();
        end
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if (acc[p] != 100 || rsp[p] != 100) begin
                n_err++; $display("FAIL stream_count p%0d: got accepts=%0d resps=%0d required 100/100",
                                  p, acc[p], rsp[p]);
            end
        end
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                set_req(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3), $urandom_range(0, 255));
                want[p] = 1'($urandom_range(0, 3) != 0);
            end
            prep();
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if ((req_v[p] && rdy[p] !== exp_rdy[p]) || ram_v[p] !== exp_acc[p]
                    || (exp_acc[p] && (ram_a[p] !== req_addr[p] || ram_w[p] !== req_w[p]))) begin
                    n_err++; $display("FAIL mix_req p%0d cyc%0d: got ready=%b ram_v=%b required %b/%b",
                                      p, i, rdy[p], ram_v[p], exp_rdy[p], exp_acc[p]);
                end
                n_cmp++;
                if (rv[p] !== exp_rv[p] || (exp_rv[p] && rd[p] !== exp_rd[p])) begin
                    n_err++; $display("FAIL mix_resp p%0d cyc%0d: got v=%b d=%h required %b/%h",
                                      p, i, rv[p], rd[p], exp_rv[p], exp_rd[p]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int a = 0; a < c_ELS; a++) ref_mem[a] = 8'(a * 37 + 5);
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        want[0] = 1'b0; want[1] = 1'b0;
        yumi[0] = 1'b0; yumi[1] = 1'b0;
        idle();
        @(negedge clk_i);
        test_reset();
        test_write_then_read();
        test_ww_hazard();
        test_rw_hazard();
        test_backpressure();
        test_reset_inflight();
        test_stream();
        test_random_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
